// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin arbiter sharing one APB master port among NUM_REQ requesters
module apb_master_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_rw,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          err,
  output logic                          apb_psel,
  output logic                          apb_enab,
  output logic                          apb_rw,
  output logic [ADDR_WIDTH-1:0]         apb_addr,
  output logic [DATA_WIDTH-1:0]         apb_datai,
  input  logic [DATA_WIDTH-1:0]         apb_datao,
  input  logic                          apb_ack
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt_idx;
  logic [CW-1:0] tmo_cnt;

  logic          found;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  logic [IW-1:0] nxt_ptr;

  // Candidate index ptr+k folded back into 0..NUM_REQ-1 (k < NUM_REQ, so one subtract suffices).
  function automatic int wrap_idx(input int v);
    return (v >= NUM_REQ) ? v - NUM_REQ : v;
  endfunction

  // Round-robin search starting at the pointer; first set req bit wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'(wrap_idx(int'(ptr) + k));
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    nxt_ptr = (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
  end

  // Transfer sequencer: arbitration, APB phases, timeout and completion, all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      gnt_idx   <= '0;
      tmo_cnt   <= '0;
      done      <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      apb_psel  <= 1'b0;
      apb_enab  <= 1'b0;
      apb_rw    <= 1'b0;
      apb_addr  <= '0;
      apb_datai <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            gnt_idx   <= win;
            ptr       <= nxt_ptr;
            apb_rw    <= req_rw[win];
            apb_addr  <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
            apb_datai <= req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
            apb_psel  <= 1'b1;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          apb_enab <= 1'b1;
          tmo_cnt  <= '0;
          state    <= S_ACCESS;
        end
        S_ACCESS: begin
          // A slave ack in the same cycle the count runs out still completes cleanly.
          if (apb_ack) begin
            if (!apb_rw) begin
              rdata <= apb_datao;
            end
            err      <= 1'b0;
            done     <= NUM_REQ'(1) << gnt_idx;
            apb_psel <= 1'b0;
            apb_enab <= 1'b0;
            state    <= S_RESP;
          end else if (tmo_cnt == CW'(TIMEOUT)) begin
            err      <= 1'b1;
            done     <= NUM_REQ'(1) << gnt_idx;
            apb_psel <= 1'b0;
            apb_enab <= 1'b0;
            state    <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        default: begin
          done  <= '0;
          err   <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - self-checking bench for apb_master_arbiter
module tb_apb_master_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req;
  logic [NR-1:0]    req_rw;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    done;
  logic [DW-1:0]    rdata;
  logic             err;
  logic             apb_psel;
  logic             apb_enab;
  logic             apb_rw;
  logic [AW-1:0]    apb_addr;
  logic [DW-1:0]    apb_datai;
  logic [DW-1:0]    apb_datao;
  logic             apb_ack;

  // slave model: acks after wait_n ACCESS cycles when enabled
  logic [DW-1:0]    sdata;
  int               wait_n;
  logic             ack_en;
  logic [7:0]       acc;

  int total = 0;
  int bad   = 0;

  apb_master_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .rdata(rdata), .err(err),
    .apb_psel(apb_psel), .apb_enab(apb_enab), .apb_rw(apb_rw), .apb_addr(apb_addr),
    .apb_datai(apb_datai), .apb_datao(apb_datao), .apb_ack(apb_ack)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (!apb_enab) acc <= 8'd0;
    else           acc <= acc + 8'd1;
  end

  assign apb_ack   = ack_en && apb_enab && (int'(acc) >= wait_n);
  assign apb_datao = sdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          idx;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] sdata;
    int          wait_n;
    logic        ack_en;
    int          lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt[5];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int            lat;
    int            enab_n;
    bit            seen;
    logic [NR-1:0] expd;
    lat    = 0;
    enab_n = 0;
    seen   = 1'b0;
    expd   = '0;
    expd[v.idx] = 1'b1;
    @(negedge clk);
    req_rw[v.idx]              = v.rw;
    req_addr[v.idx*AW +: AW]   = v.addr;
    req_wdata[v.idx*DW +: DW]  = v.wdata;
    sdata  = v.sdata;
    wait_n = v.wait_n;
    ack_en = v.ack_en;
    req    = expd;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk($sformatf("v%0d setup psel_enab", n), 64'({apb_psel, apb_enab}), 64'b10);
        chk($sformatf("v%0d setup rw", n), 64'(apb_rw), 64'(v.rw));
        chk($sformatf("v%0d setup datai", n), 64'(apb_datai), 64'(v.wdata));
      end
      if (apb_psel) begin
        chk($sformatf("v%0d addr cyc%0d", n, k), 64'(apb_addr), 64'(v.addr));
      end
      if (apb_enab) enab_n++;
      if (done != '0) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    req = '0;
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL v%0d done_timeout actual=none required=done", n);
    end else begin
      chk($sformatf("v%0d latency", n), 64'(lat), 64'(v.lat));
      chk($sformatf("v%0d done", n), 64'(done), 64'(expd));
      chk($sformatf("v%0d err", n), 64'(err), 64'(v.exp_err));
      chk($sformatf("v%0d rdata", n), 64'(rdata), 64'(v.exp_rdata));
      chk($sformatf("v%0d enab_cycles", n), 64'(enab_n), 64'(v.lat - 2));
    end
    @(negedge clk);
    chk($sformatf("v%0d done_one_cycle", n), 64'(done), 64'd0);
  endtask

  initial begin
    int            cyc[$];
    logic [NR-1:0] dv[$];
    bit            seen;
    int            lat;

    reset     = 1'b1;
    req       = '0;
    req_rw    = '0;
    req_addr  = '0;
    req_wdata = '0;
    sdata     = '0;
    wait_n    = 0;
    ack_en    = 1'b1;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset outputs", 64'({done, err, apb_psel, apb_enab, apb_rw}), 64'd0);
    chk("reset rdata", 64'(rdata), 64'd0);
    chk("reset addr", 64'(apb_addr), 64'd0);
    chk("reset datai", 64'(apb_datai), 64'd0);
    reset = 1'b0;

    //        idx rw addr          wdata          sdata          wait ack lat rdata          err
    vt[0] = '{0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'hAAAA_0000, 0, 1'b1, 3, 32'h0000_0000, 1'b0};
    vt[1] = '{1, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'h1234_5678, 0, 1'b1, 3, 32'h1234_5678, 1'b0};
    vt[2] = '{0, 1'b1, 32'h0000_0010, 32'h0BAD_F00D, 32'hFFFF_0000, 3, 1'b1, 6, 32'h1234_5678, 1'b0};
    vt[3] = '{1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'hCAFE_0001, 0, 1'b0, 7, 32'h1234_5678, 1'b1};
    vt[4] = '{0, 1'b0, 32'h0000_0024, 32'h0000_0000, 32'h5555_AAAA, 1, 1'b1, 4, 32'h5555_AAAA, 1'b0};

    for (int i = 0; i < 5; i++) run_vec(vt[i], i);

    // contention: both held from reset, grants alternate every 4 cycles
    @(negedge clk);
    reset  = 1'b1;
    ack_en = 1'b1;
    wait_n = 0;
    req    = 2'b11;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (done != '0) begin
        cyc.push_back(c);
        dv.push_back(done);
      end
    end
    req = '0;
    chk("contention pulses", 64'(cyc.size()), 64'd4);
    for (int i = 0; i < 4 && i < cyc.size(); i++) begin
      chk($sformatf("contention cyc%0d", i), 64'(cyc[i]), 64'(3 + 4*i));
      chk($sformatf("contention gnt%0d", i), 64'(dv[i]), (i % 2 == 0) ? 64'b01 : 64'b10);
    end

    // reset during ACCESS, pointer returns to 0
    do_reset();
    ack_en = 1'b0;
    req    = 2'b01;
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset enab", 64'(apb_enab), 64'd1);
    reset = 1'b1;
    #1;
    chk("async reset psel_enab", 64'({apb_psel, apb_enab}), 64'd0);
    chk("async reset done", 64'(done), 64'd0);
    chk("async reset addr", 64'(apb_addr), 64'd0);
    @(negedge clk);
    reset  = 1'b0;
    ack_en = 1'b1;
    req    = 2'b11;
    seen   = 1'b0;
    lat    = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (done != '0) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    req = '0;
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL post_reset done_timeout actual=none required=done");
    end else begin
      chk("post_reset gnt", 64'(done), 64'b01);
      chk("post_reset latency", 64'(lat), 64'd3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
